// File: rtl/fe_fifo_reader_pkg.sv
// Shared FE capture-FIFO encodings: command codes, status-bit positions and the event payload.
package fe_fifo_reader_pkg;

    localparam logic [1:0] FE_FIFO_CMD_DATA = 2'd1;
    localparam logic [1:0] FE_FIFO_CMD_STAT = 2'd2;
    localparam logic [1:0] FE_FIFO_CMD_TIME = 2'd3;

    // Status bits sit at FE_FIFO_STATUS_BITS_START in the packed FIFO word.
    localparam int unsigned FE_FIFO_STATUS_BITS_START = 8;
    localparam int unsigned FE_FIFO_RXACTIVE_BIT      = 9;
    localparam int unsigned FE_FIFO_RXACTIVE_IDX      =
        FE_FIFO_RXACTIVE_BIT - FE_FIFO_STATUS_BITS_START;

    typedef struct packed {
        logic       is_data;
        logic [7:0] data;
        logic [4:0] status;
        logic       sop;
        logic       eop;
    } fe_event_t;

endpackage

// File: rtl/fe_fifo_reader.sv
// Drains the FE capture FIFO into a valid/ready event stream with absolute timestamps and framing.
// Define FE_READER_PKT_STATS_EN to build the packet count / last-length statistics.
module fe_fifo_reader
    import fe_fifo_reader_pkg::*;
#(
    parameter int unsigned pTIME_ACC_WIDTH       = 32,
    parameter int unsigned pTIMESTAMP_FULL_WIDTH = 16
) (
    input  logic                             fe_clk,
    input  logic                             reset_i,
    input  logic                             I_clear,
    input  logic                             I_fifo_empty,
    input  logic [1:0]                       I_command,
    input  logic [pTIMESTAMP_FULL_WIDTH-1:0] I_time,
    input  logic [7:0]                       I_data,
    input  logic [4:0]                       I_status,
    output logic                             O_fifo_rd,
    output logic                             O_event_valid,
    input  logic                             I_event_ready,
    output logic [pTIME_ACC_WIDTH-1:0]       O_event_time,
    output logic                             O_event_is_data,
    output logic [7:0]                       O_event_data,
    output logic [4:0]                       O_event_status,
    output logic                             O_event_sop,
    output logic                             O_event_eop,
    output logic                             O_error,
    output logic [15:0]                      O_pkt_count,
    output logic [15:0]                      O_last_pkt_len
);

    typedef enum logic [1:0] {S_IDLE, S_SOP_PEND, S_IN_PKT} frame_state_e;

    frame_state_e               state_q, state_d;
    logic [pTIME_ACC_WIDTH-1:0] acc_q, acc_d, time_q, time_d, acc_sum;
    logic                       valid_q, valid_d, err_q, err_d;
    fe_event_t                  ev_q, ev_d;
    logic                       pop, rxactive;

    assign acc_sum = acc_q + pTIME_ACC_WIDTH'(I_time);

    always_comb begin
        pop      = !I_fifo_empty && (!valid_q || I_event_ready) && !reset_i && !I_clear;
        rxactive = I_status[FE_FIFO_RXACTIVE_IDX];
        state_d  = state_q;
        acc_d    = acc_q;
        time_d   = time_q;
        ev_d     = ev_q;
        err_d    = err_q;
        valid_d  = valid_q && !I_event_ready;
        if (pop) begin
            case (I_command)
                FE_FIFO_CMD_TIME: acc_d = acc_sum;
                FE_FIFO_CMD_DATA: begin
                    acc_d   = acc_sum;
                    time_d  = acc_sum;
                    valid_d = 1'b1;
                    ev_d    = '{is_data: 1'b1, data: I_data, status: I_status,
                                sop: (state_q == S_SOP_PEND), eop: 1'b0};
                    if (state_q == S_SOP_PEND) state_d = S_IN_PKT;
                end
                FE_FIFO_CMD_STAT: begin
                    acc_d   = acc_sum;
                    time_d  = acc_sum;
                    valid_d = 1'b1;
                    ev_d    = '{is_data: 1'b0, data: I_data, status: I_status,
                                sop: 1'b0, eop: (!rxactive && state_q == S_IN_PKT)};
                    if (rxactive && state_q == S_IDLE) state_d = S_SOP_PEND;
                    else if (!rxactive)                state_d = S_IDLE;
                end
                // Undefined code: entry is consumed and dropped, time untouched.
                default: err_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge fe_clk) begin
        if (reset_i || I_clear) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            time_q  <= '0;
            ev_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            time_q  <= time_d;
            ev_q    <= ev_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign O_fifo_rd       = pop;
    assign O_event_valid   = valid_q;
    assign O_event_time    = time_q;
    assign O_event_is_data = ev_q.is_data;
    assign O_event_data    = ev_q.data;
    assign O_event_status  = ev_q.status;
    assign O_event_sop     = ev_q.sop;
    assign O_event_eop     = ev_q.eop;
    assign O_error         = err_q;

`ifdef FE_READER_PKT_STATS_EN
    logic [15:0] byte_cnt_q, byte_cnt_d, pkt_cnt_q, pkt_cnt_d, last_len_q, last_len_d;

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        last_len_d = last_len_q;
        if (pop && I_command == FE_FIFO_CMD_DATA) begin
            if (state_q == S_SOP_PEND) begin
                byte_cnt_d = 16'd1;
            end else if (state_q == S_IN_PKT && byte_cnt_q != 16'hFFFF) begin
                byte_cnt_d = byte_cnt_q + 16'd1;
            end
        end
        if (pop && I_command == FE_FIFO_CMD_STAT && !rxactive && state_q == S_IN_PKT) begin
            last_len_d = byte_cnt_q;
            pkt_cnt_d  = pkt_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge fe_clk) begin
        if (reset_i || I_clear) begin
            byte_cnt_q <= '0;
            pkt_cnt_q  <= '0;
            last_len_q <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            last_len_q <= last_len_d;
        end
    end

    assign O_pkt_count    = pkt_cnt_q;
    assign O_last_pkt_len = last_len_q;
`else
    assign O_pkt_count    = '0;
    assign O_last_pkt_len = '0;
`endif

endmodule

// File: doc/fe_fifo_reader.md
FE_FIFO_READER -- requirements
Module: fe_fifo_reader

Interface
REQ-001 SHALL have parameter pTIME_ACC_WIDTH, default 32, absolute-time accumulator width.
REQ-002 SHALL have parameter pTIMESTAMP_FULL_WIDTH, default 16, width of the FIFO time field.
REQ-003 fe_clk  in  1  sole clock; one clock, all logic on its rising edge.
REQ-004 reset_i  in  1  reset; synchronous, active-high.
REQ-005 I_clear  in  1  one-cycle pulse: restart decode (accumulator, framing, stats, error).
REQ-006 I_fifo_empty  in  1  capture FIFO empty (first-word-fall-through).
REQ-007 I_command  in  2  head-entry command.
REQ-008 I_time  in  pTIMESTAMP_FULL_WIDTH  head-entry time delta.
REQ-009 I_data  in  8  head-entry data byte.
REQ-010 I_status  in  5  head-entry status bits.
REQ-011 O_fifo_rd  out  1  pop head entry.
REQ-012 O_event_valid  out  1  event held on O_event_*.
REQ-013 I_event_ready  in  1  consumer accepts event.
REQ-014 O_event_time  out  pTIME_ACC_WIDTH  absolute event time.
REQ-015 O_event_is_data  out  1  1 = DATA event, 0 = STAT event.
REQ-016 O_event_data / O_event_status  out  8 / 5  payload.
REQ-017 O_event_sop  out  1  first DATA byte of a packet.
REQ-018 O_event_eop  out  1  STAT event closing a packet.
REQ-019 O_error  out  1  sticky: undefined command code popped.
REQ-020 O_pkt_count / O_last_pkt_len  out  16 / 16  packet statistics.

Function
REQ-021 SHALL pop (O_fifo_rd=1, combinational) when !I_fifo_empty && (!O_event_valid || I_event_ready) && !reset_i && !I_clear.
REQ-022 Popped FE_FIFO_CMD_TIME: acc += I_time; no event; O_event_valid deasserts if the held event was accepted.
REQ-023 Popped FE_FIFO_CMD_DATA/FE_FIFO_CMD_STAT: acc += I_time; next cycle O_event_valid=1, O_event_time = updated acc, payload registered.
REQ-024 Latency: head entry visible -> O_event_valid one cycle later; sustained 1 event/cycle with I_event_ready held 1.
REQ-025 O_event_* SHALL hold stable while O_event_valid && !I_event_ready.
REQ-026 Accumulator SHALL add zero-extended I_time and wrap modulo 2^pTIME_ACC_WIDTH.
REQ-027 Framing FSM states: S_IDLE, S_SOP_PEND, S_IN_PKT.
REQ-028 S_IDLE -> S_SOP_PEND on STAT with rxactive bit=1 (bit per FE_FIFO_RXACTIVE_BIT - FE_FIFO_STATUS_BITS_START).
REQ-029 S_SOP_PEND -> S_IN_PKT on DATA; that event carries O_event_sop=1.
REQ-030 S_SOP_PEND or S_IN_PKT -> S_IDLE on STAT with rxactive=0; that event carries O_event_eop=1 only from S_IN_PKT.
REQ-031 DATA in S_IDLE: emitted, sop=0, no state change.
REQ-032 Undefined command: popped, discarded, O_error set, accumulator unchanged.
REQ-033 I_clear takes priority over a pop the same cycle: no pop, acc=0, FSM S_IDLE, O_event_valid=0, O_error=0, stats=0.

Reset
REQ-034 reset_i SHALL clear acc, O_event_valid, O_fifo_rd, O_event_* (all 0), O_error, stats; FSM S_IDLE.
REQ-035 Reset mid-event SHALL discard the held event; no pop in a reset cycle.

Configuration
REQ-036 With FE_READER_PKT_STATS_EN defined: byte counter increments per DATA in S_IN_PKT (sop byte counts 1), saturates at 0xFFFF; on eop, O_last_pkt_len = count and O_pkt_count += 1 (wraps).
REQ-037 Without FE_READER_PKT_STATS_EN: O_pkt_count and O_last_pkt_len tied to 0; no counter logic.

Structure
REQ-038 Command codes and status-bit indices SHALL come from the shared defines (FE_FIFO_CMD_*, FE_FIFO_*_BIT); framing state encodings local.
REQ-039 Single flat module; no sub-module.

Verification
REQ-040 TIME 0xFFFE, then DATA time=3 data=0xA5 -> one event, time=0x10001, is_data=1, data=0xA5.
REQ-041 STAT rxactive=1, DATA x3, STAT rxactive=0 -> 5 events; first DATA sop=1; last STAT eop=1; O_last_pkt_len=3, O_pkt_count=1 (macro on), both 0 (macro off).
REQ-042 I_event_ready low 4 cycles with FIFO non-empty -> O_fifo_rd=0, payload stable, then one pop per cycle once ready rises.
REQ-043 acc=0xFFFFFFFE, DATA time=5 -> O_event_time=3.
REQ-044 Undefined command mid-stream -> O_error=1 sticky, no event, next DATA time unaffected; I_clear -> O_error=0, acc=0.
REQ-045 reset_i asserted while O_event_valid=1 -> next cycle O_event_valid=0, all outputs 0.
